message_receiver: RTL

Receive-side counterpart of the sensor messaging path. It consumes 16-bit words from the SPI receive interface and hunts for a sync word. It then reassembles a frame of SENSORS×2 channel values, each BITWIDTH bits wide, and verifies a 16-bit additive checksum. Good frames are presented on a flat parallel output with a valid/ack handshake. The block sits between the SPI core and the control logic that consumes host-supplied values (calibration or setpoints).

---
 rtl/msg_pkg.sv | 20 ++
 rtl/msg_checksum.sv | 26 ++
 rtl/message_receiver.sv | 129 ++++++++++++
 3 files changed

// File: rtl/msg_pkg.sv
// Framing constants and types shared by both ends of the sensor messaging path.
package msg_pkg;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hA55A;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } msg_state_t;

  function automatic int msg_words(input int sensors, input int bitwidth);
    return sensors * 2 * bitwidth / 16;
  endfunction

  function automatic int msg_wpc(input int bitwidth);
    return bitwidth / 16;
  endfunction

endpackage

// File: rtl/msg_checksum.sv
// 16-bit additive frame checksum: clear, accumulate, compare.
module msg_checksum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        add,
  input  logic [15:0] word,
  input  logic [15:0] chk,
  output logic        match
);

  logic [15:0] sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + word;
    end
  end

  assign match = (sum == chk);

endmodule

// File: rtl/message_receiver.sv
// Hunts for a sync word, reassembles a checksummed frame and
// presents good frames on a valid/ack output.
module message_receiver
  import msg_pkg::*;
#(
  parameter int          SENSORS   = 1,
  parameter int          BITWIDTH  = 32,
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   spi_in,
  input  logic                          spi_rx_ready,
  output logic                          read,
  output logic [SENSORS*2*BITWIDTH-1:0] data,
  output logic                          data_valid,
  input  logic                          ack,
  output logic                          frame_error
);

  localparam int WORDS = msg_words(SENSORS, BITWIDTH);
  localparam int WPC   = msg_wpc(BITWIDTH);
  localparam int CW    = $clog2(WORDS) + 1;
  localparam int DW    = SENSORS * 2 * BITWIDTH;

  msg_state_t    state;
  msg_state_t    state_nx;
  logic [CW-1:0] cnt;
  logic [DW-1:0] stage;

  logic sum_clr;
  logic sum_add;
  logic match;
  logic commit;
  logic fail;

  msg_checksum u_sum (
    .clk   (clk),
    .rst   (rst),
    .clear (sum_clr),
    .add   (sum_add),
    .word  (spi_in),
    .chk   (spi_in),
    .match (match)
  );

  always_comb begin
    state_nx = state;
    read     = 1'b0;
    sum_clr  = 1'b0;
    sum_add  = 1'b0;
    commit   = 1'b0;
    fail     = 1'b0;
    unique case (state)
      HUNT: begin
        read = spi_rx_ready;
        if (spi_rx_ready && spi_in == SYNC_WORD) begin
          sum_clr  = 1'b1;
          state_nx = PAYLOAD;
        end
      end
      PAYLOAD: begin
        read    = spi_rx_ready;
        sum_add = spi_rx_ready;
        if (spi_rx_ready && cnt == CW'(WORDS - 1)) begin
          state_nx = CHECK;
        end
      end
      CHECK: begin
        // hold the checksum word in the SPI core until the old frame is taken
        read = spi_rx_ready && (!data_valid || ack);
        if (read) begin
          commit   = match;
          fail     = !match;
          state_nx = HUNT;
        end
      end
      default: state_nx = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (sum_clr) begin
      cnt <= '0;
    end else if (sum_add) begin
      cnt <= cnt + 1'b1;
    end
  end

  // channel 0 first on the wire, most significant half of a channel first
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else if (sum_add) begin
      for (int i = 0; i < WORDS; i++) begin
        if (cnt == CW'(i)) begin
          stage[((i / WPC) * WPC + (WPC - 1 - i % WPC)) * 16 +: 16] <= spi_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data        <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= fail;
      if (commit) begin
        data       <= stage;
        data_valid <= 1'b1;
      end else if (ack && data_valid) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
